// File: rtl/bitwise_unit_mc_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the multicycle bitwise unit.
package bitwise_unit_mc_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_ANDN  = 3'b101;
    localparam logic [2:0] OP_XNOR  = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Slice counter width; a single-slice configuration still keeps a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/bitwise_unit_mc_logic_slice.sv
// Combinational bitwise function on one SLICE-bit chunk of the operands.
module bitwise_unit_mc_logic_slice
    import bitwise_unit_mc_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    // Decode the opcode into the selected bitwise operation.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_ANDN:  y = a & ~b;
            OP_XNOR:  y = ~(a ^ b);
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_unit_mc.sv
// Multicycle bitwise logic unit: processes SLICE bits per clock under a start/ready handshake.
module bitwise_unit_mc
    import bitwise_unit_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             busy,
    output logic             isZero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("bitwise_unit_mc: WIDTH must be a multiple of SLICE");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   shadow_q;

    logic [SLICE-1:0]   a_slice;
    logic [SLICE-1:0]   b_slice;
    logic [SLICE-1:0]   y_slice;
    logic [WIDTH-1:0]   merged;

    assign a_slice = a_q[cnt_q*SLICE +: SLICE];
    assign b_slice = b_q[cnt_q*SLICE +: SLICE];

    bitwise_unit_mc_logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op (op_q),
        .a  (a_slice),
        .b  (b_slice),
        .y  (y_slice)
    );

    // Shadow value with the current slice result folded in; becomes the full result on the last slice.
    always_comb begin
        merged = shadow_q;
        merged[cnt_q*SLICE +: SLICE] = y_slice;
    end

    // FSM, slice counter, operand latches and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            shadow_q   <= '0;
            result     <= '0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
            isZero     <= 1'b1;
        end else begin
            result_rdy <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ctrl_start) begin
                        op_q    <= op;
                        a_q     <= operandA;
                        b_q     <= operandB;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    shadow_q <= merged;
                    if (cnt_q == LAST_CNT) begin
                        // Result only ever changes here, so it never exposes a partial value.
                        result     <= merged;
                        isZero     <= (merged == '0);
                        result_rdy <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
